// File: rtl/arith_unit_seq.sv
// rtl/arith_unit_seq.sv - handshaked ADD/SUB/MUL/DIV/MOD unit with multi-cycle restoring divider
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; op, in1 (dividend), in2 (divisor)
//   out_valid / out_ready result handshake
//   result, result_hi    primary result, MUL upper half
//   carry                ADD carry-out / SUB borrow
//   div_zero, op_err     divide-by-zero and reserved-opcode status
module arith_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             div_zero,
    output logic             op_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   rem_q, quot_q, divisor_q;
    logic [CW-1:0]      count_q;
    logic               is_mod_q;

    logic               accept;
    logic               div_start;
    logic               last_step;
    logic [WIDTH:0]     add_full;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quot_nxt;

    // in_ready also depends combinationally on out_ready so that a result can
    // retire and a new operand be taken on the same edge.
    assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign div_start = ((op == OP_DIV) || (op == OP_MOD)) && (in2 != '0);
    assign last_step = (state == S_BUSY) && (count_q == LAST_STEP);
    assign add_full  = {1'b0, in1} + {1'b0, in2};
    assign prod      = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

    // One restoring step: shift the next dividend bit (held in quot_q's MSB)
    // into the partial remainder and keep the subtraction only if it did not go negative.
    always_comb begin
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        rem_nxt   = rem_shift[WIDTH-1:0];
        quot_nxt  = {quot_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt  = trial[WIDTH-1:0];
            quot_nxt = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = div_start ? S_BUSY : S_DONE;
            S_BUSY: if (last_step) state_nxt = S_DONE;
            S_DONE: if (out_ready) begin
                if (accept) state_nxt = div_start ? S_BUSY : S_DONE;
                else        state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            div_zero  <= 1'b0;
            op_err    <= 1'b0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            is_mod_q  <= 1'b0;
        end else if (accept) begin
            // Fields not defined for the new op read as zero.
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            div_zero  <= 1'b0;
            op_err    <= 1'b0;
            case (op)
                OP_ADD: begin
                    result <= add_full[WIDTH-1:0];
                    carry  <= add_full[WIDTH];
                end
                OP_SUB: begin
                    result <= in1 - in2;
                    carry  <= (in1 < in2);
                end
                OP_MUL: begin
                    result    <= prod[WIDTH-1:0];
                    result_hi <= prod[2*WIDTH-1:WIDTH];
                end
                OP_DIV, OP_MOD: begin
                    if (in2 == '0) begin
                        result   <= (op == OP_DIV) ? {WIDTH{1'b1}} : in1;
                        div_zero <= 1'b1;
                    end else begin
                        rem_q     <= '0;
                        quot_q    <= in1;
                        divisor_q <= in2;
                        count_q   <= '0;
                        is_mod_q  <= (op == OP_MOD);
                    end
                end
                default: op_err <= 1'b1;
            endcase
        end else if (state == S_BUSY) begin
            rem_q   <= rem_nxt;
            quot_q  <= quot_nxt;
            count_q <= count_q + 1'b1;
            if (last_step) result <= is_mod_q ? rem_nxt : quot_nxt;
        end
    end

endmodule

// File: tb/tb_arith_unit_seq.sv
// tb/tb_arith_unit_seq.sv - directed self-checking bench for arith_unit_seq
module tb_arith_unit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] in1, in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic         carry, div_zero, op_err;

    int checks = 0;
    int errors = 0;

    arith_unit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .carry(carry), .div_zero(div_zero), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents one transaction, measures latency to out_valid, checks all result
    // fields, then retires the result. Called #1 after a rising edge.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int e_res, input int e_hi,
                         input int e_c, input int e_dz, input int e_err, input int e_lat);
        int lat;
        int busy_rdy;
        int guard;
        op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = '0; in2 = '0; op = 3'd7;
        lat = 1; busy_rdy = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy++;
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_busy_in_ready"}, busy_rdy, 0);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, result, e_res);
        check({tag, "_hi"}, result_hi, e_hi);
        check({tag, "_carry"}, carry, e_c);
        check({tag, "_dz"}, div_zero, e_dz);
        check({tag, "_err"}, op_err, e_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_retire"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_res", result, 0);
        check("rst_flags", {result_hi, carry, div_zero, op_err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        do_op("add", 3'd0, 8'd200, 8'd100, 44, 0, 1, 0, 0, 1);
        do_op("sub", 3'd1, 8'd5, 8'd7, 254, 0, 1, 0, 0, 1);
        do_op("mul1", 3'd2, 8'd200, 8'd3, 8'h58, 8'h02, 0, 0, 0, 1);
        do_op("mul2", 3'd2, 8'd15, 8'd17, 255, 0, 0, 0, 0, 1);
        do_op("div", 3'd3, 8'd200, 8'd7, 28, 0, 0, 0, 0, 9);
        do_op("mod", 3'd4, 8'd200, 8'd7, 4, 0, 0, 0, 0, 9);
        do_op("div0", 3'd3, 8'd8, 8'd0, 8'hFF, 0, 0, 1, 0, 1);
        do_op("mod0", 3'd4, 8'd8, 8'd0, 8, 0, 0, 1, 0, 1);
        do_op("rsvd", 3'd6, 8'd9, 8'd3, 0, 0, 0, 0, 1, 1);

        // Back-pressure: ADD 10+20 held for 5 cycles with out_ready low.
        op = 3'd0; in1 = 8'd10; in2 = 8'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in1 = 8'd99; in2 = 8'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_res", result, 30);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_retire", out_valid, 0);

        // Streaming: one ADD per cycle with both handshakes held high.
        op = 3'd0; in1 = 8'd1; in2 = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("str1_valid", out_valid, 1);
        check("str1_res", result, 2);
        in1 = 8'd2; in2 = 8'd2;
        @(posedge clk); #1;
        check("str2_valid", out_valid, 1);
        check("str2_res", result, 4);
        in1 = 8'd3; in2 = 8'd3;
        @(posedge clk); #1;
        check("str3_valid", out_valid, 1);
        check("str3_res", result, 6);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("str_drain", out_valid, 0);

        // Reset 4 cycles into a DIV.
        op = 3'd3; in1 = 8'd200; in2 = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_outs", {result, result_hi, carry, div_zero, op_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("mid_rst_quiet", {out_valid, result}, 0);
        end
        do_op("add_after_rst", 3'd0, 8'd1, 8'd1, 2, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/arith_unit_seq.md
# arith_unit_seq

Parametrised, handshaked successor to the team's 4-bit combinational arithmetic block. It executes one of ADD, SUB, MUL, DIV or MOD on two WIDTH-bit unsigned operands per transaction. DIV and MOD use a multi-cycle restoring divider; the other ops take one cycle. The block sits between an operand source and a result sink, both using valid/ready handshakes, and reports carry/borrow, MUL upper half, divide-by-zero and illegal-opcode status.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source presents a transaction.
- in_ready  out  1  block accepts the transaction when in_valid && in_ready at a rising edge.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5–7 reserved.
- in1  in  WIDTH  operand A (dividend).
- in2  in  WIDTH  operand B (divisor).
- out_valid  out  1  result fields are valid.
- out_ready  in  1  sink takes the result when out_valid && out_ready at a rising edge.
- result  out  WIDTH  primary result: sum, difference, product low half, quotient or remainder.
- result_hi  out  WIDTH  MUL product upper half; 0 for all other ops.
- carry  out  1  ADD carry-out / SUB borrow (in1 < in2); 0 otherwise.
- div_zero  out  1  DIV/MOD with in2 == 0.
- op_err  out  1  reserved opcode received.

## Operation
- Inputs are captured at the accepting edge and may change freely afterward.
- FSM states are IDLE, BUSY and DONE.
- **IDLE:** in_ready=1. On accept:
  - DIV/MOD with in2≠0 → BUSY, divider loaded.
  - Anything else → result registered, go to DONE.
- **BUSY:** one restoring-division step per cycle, WIDTH steps total. After the last step, register the quotient (DIV) or remainder (MOD) and go to DONE. in_ready=0.
- **DONE:** out_valid=1, and all result outputs are held stable until handshake.
  - out_ready=1 and in_valid=0 → IDLE.
  - out_ready=1 and in_valid=1 → accept the new transaction in the same cycle (same rules as IDLE). This lets single-cycle ops stream at one per cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready and is accepted as such.
- **Arithmetic:** all operands unsigned, results truncated mod 2^WIDTH.
  - ADD: {carry, result} = in1 + in2.
  - SUB: result = in1 − in2 mod 2^WIDTH; carry = (in1 < in2).
  - MUL: {result_hi, result} = in1 × in2 (2·WIDTH bits).
  - DIV/MOD: quotient/remainder of in1 / in2.
- **Divide by zero:** completes in one cycle with no BUSY.
  - DIV → result = all ones.
  - MOD → result = in1.
  - div_zero=1.
- **Reserved opcode:** one cycle; result = 0, result_hi = 0, op_err = 1.
- Every result field not defined for the executed op is driven to 0.

## Timing
- **Reset (rst_n low, async):** state=IDLE; out_valid, result, result_hi, carry, div_zero and op_err all 0. in_ready is forced to 0 while rst_n is low and goes to 1 in the first cycle after release.
- **Reset mid-operation:** BUSY/DONE are abandoned immediately and no result is produced.
- **Single-cycle ops** (ADD, SUB, MUL, div-by-zero, reserved): out_valid=1 in the cycle following the accepting edge.
- **DIV/MOD with in2≠0:** out_valid rises after the (WIDTH+1)-th rising edge counted from the accepting edge (inclusive). in_ready stays 0 throughout.
- **Back-pressure:** out_valid and all result fields stay constant while out_valid && !out_ready, for any number of cycles.
- **Peak throughput:** one single-cycle op per clock with out_ready held high; one DIV/MOD per WIDTH+1 cycles.

## Test plan
All scenarios use WIDTH=8.
- **Reset then ADD:** 200+100 → result 44, carry 1, out_valid one cycle after accept. **SUB:** 5−7 → result 254, carry 1.
- **MUL:** 200×3 → result 0x58, result_hi 0x02. **MUL:** 15×17 → result 255, result_hi 0.
- **DIV/MOD:** DIV 200/7 → 28 and MOD 200/7 → 4, each with out_valid exactly 9 edges after accept and in_ready 0 meanwhile. **Divide by zero:** DIV 8/0 → 0xFF, div_zero 1; MOD 8/0 → 8, div_zero 1; both latency 1.
- **Reserved opcode:** op=6 → result 0, op_err 1. **Back-pressure:** hold out_ready=0 for 5 cycles after an ADD; the result stays stable and in_ready stays 0.
- **Streaming:** out_ready=1 and in_valid=1 continuously with ADD operand pairs (1,1),(2,2),(3,3) → results 2, 4, 6 on three consecutive cycles.
- **Reset mid-DIV:** pulse rst_n low 4 cycles into a DIV → out_valid stays 0 and all outputs are 0. A following ADD 1+1 → 2 completes normally.
